// File: rtl/registro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : registro_pkg
// Description : Shared definitions for the universal register family.
//               Holds the operation-select encodings used by the top module,
//               the per-bit cell and any bench that drives them.
// Revision    : 1.0 - initial release
// ============================================================================
package registro_pkg;

    // Operation select encodings for the 2-bit modo input
    localparam logic [1:0] MODO_RETENER = 2'b00;  // hold
    localparam logic [1:0] MODO_DER     = 2'b01;  // shift right (towards Q[0])
    localparam logic [1:0] MODO_IZQ     = 2'b10;  // shift left (towards Q[N-1])
    localparam logic [1:0] MODO_CARGA   = 2'b11;  // parallel load

endpackage : registro_pkg
`default_nettype wire

// File: rtl/celda_universal.sv
`default_nettype none
// ============================================================================
// Module      : celda_universal
// Description : One bit of the universal register. A 4:1 mux selects hold,
//               the neighbour feeding a right shift, the neighbour feeding a
//               left shift, or the parallel-load bit, into a flip-flop with
//               asynchronous active-low reset.
// Ports       : clk         - rising-edge clock
//               reset_async - asynchronous reset, active-low
//               modo        - operation select (registro_pkg encodings)
//               d_der       - bit taken on a right shift (from Q[i+1])
//               d_izq       - bit taken on a left shift (from Q[i-1])
//               d_carga     - parallel load bit
//               q           - stored bit
// Revision    : 1.0 - initial release
// ============================================================================
module celda_universal
    import registro_pkg::*;
(
    input  logic       clk,
    input  logic       reset_async,
    input  logic [1:0] modo,
    input  logic       d_der,
    input  logic       d_izq,
    input  logic       d_carga,
    output logic       q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            r_q <= 1'b0;
        end else begin
            // Any unknown select falls through to default and holds
            case (modo)
                MODO_DER:   r_q <= d_der;
                MODO_IZQ:   r_q <= d_izq;
                MODO_CARGA: r_q <= d_carga;
                default:    r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule : celda_universal
`default_nettype wire

// File: rtl/registro_universal_nbits.sv
`default_nettype none
// ============================================================================
// Module      : registro_universal_nbits
// Description : N-bit universal register (hold / shift right / shift left /
//               parallel load) with a saturating shift counter reporting how
//               many original bits have left the register since the last
//               load or reset.
//               Compile-time option: define ROTATE_EN to add the rot input,
//               which turns shifts into rotations that count modulo N and
//               pulse vuelta on wrap. Without it vuelta is tied low.
// Ports       : clk          - rising-edge clock
//               reset_async  - asynchronous reset, active-low
//               modo         - operation select (registro_pkg encodings)
//               In           - parallel load data
//               ser_in_der   - serial bit entering Q[N-1] on shift right
//               ser_in_izq   - serial bit entering Q[0] on shift left
//               rot          - rotate select (ROTATE_EN only)
//               Q            - register contents
//               ser_out_der  - Q[0]
//               ser_out_izq  - Q[N-1]
//               cuenta       - shifts since last load/reset
//               vacio        - cuenta == N
//               vuelta       - one-cycle pulse after a rotate wrap
// Revision    : 1.0 - initial release
// ============================================================================
module registro_universal_nbits
    import registro_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset_async,
    input  logic [1:0]    modo,
    input  logic [N-1:0]  In,
    input  logic          ser_in_der,
    input  logic          ser_in_izq,
`ifdef ROTATE_EN
    input  logic          rot,
`endif
    output logic [N-1:0]  Q,
    output logic          ser_out_der,
    output logic          ser_out_izq,
    output logic [CW-1:0] cuenta,
    output logic          vacio,
    output logic          vuelta
);

    localparam logic [CW-1:0] c_n   = CW'(N);
    localparam logic [CW-1:0] c_uno = CW'(1);

    logic [N-1:0]  w_q;
    logic          w_rotar;
    logic          w_ent_der;
    logic          w_ent_izq;
    logic [N-1:0]  w_vec_der;
    logic [N-1:0]  w_vec_izq;
    logic [CW-1:0] w_cuenta_sig;
    logic          w_envuelve;
    logic [CW-1:0] r_cuenta;
    logic          r_vuelta;

    // Without the rotate option w_rotar is a constant 0, so the rotate paths
    // and the vuelta register reduce to nothing and vuelta is tied low.
`ifdef ROTATE_EN
    assign w_rotar = rot;
`else
    assign w_rotar = 1'b0;
`endif

    // Bits entering at the two ends: serial inputs, or the opposite end when
    // rotating.
    assign w_ent_der = w_rotar ? w_q[0]   : ser_in_der;
    assign w_ent_izq = w_rotar ? w_q[N-1] : ser_in_izq;

    // Per-bit neighbour feeds already aligned to cell index.
    assign w_vec_der = {w_ent_der, w_q[N-1:1]};
    assign w_vec_izq = {w_q[N-2:0], w_ent_izq};

    generate
        for (genvar i = 0; i < N; i++) begin : g_celdas
            celda_universal u_celda (
                .clk         (clk),
                .reset_async (reset_async),
                .modo        (modo),
                .d_der       (w_vec_der[i]),
                .d_izq       (w_vec_izq[i]),
                .d_carga     (In[i]),
                .q           (w_q[i])
            );
        end
    endgenerate

    // Counter next state. Plain shifts saturate at N; rotations count modulo
    // N, and a rotate from the saturated value N also wraps to 0.
    always_comb begin
        w_cuenta_sig = r_cuenta;
        w_envuelve   = 1'b0;
        case (modo)
            MODO_CARGA: w_cuenta_sig = '0;
            MODO_DER, MODO_IZQ: begin
                if (w_rotar) begin
                    if (r_cuenta >= (c_n - c_uno)) begin
                        w_cuenta_sig = '0;
                        w_envuelve   = 1'b1;
                    end else begin
                        w_cuenta_sig = r_cuenta + c_uno;
                    end
                end else if (r_cuenta != c_n) begin
                    w_cuenta_sig = r_cuenta + c_uno;
                end
            end
            default: w_cuenta_sig = r_cuenta;
        endcase
    end

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            r_cuenta <= '0;
            r_vuelta <= 1'b0;
        end else begin
            r_cuenta <= w_cuenta_sig;
            r_vuelta <= w_envuelve;
        end
    end

    assign Q           = w_q;
    assign ser_out_der = w_q[0];
    assign ser_out_izq = w_q[N-1];
    assign cuenta      = r_cuenta;
    assign vacio       = (r_cuenta == c_n);
    assign vuelta      = r_vuelta;

endmodule : registro_universal_nbits
`default_nettype wire

// File: tb/tb_registro_universal_nbits.sv
`default_nettype none
// ============================================================================
// Module      : tb_registro_universal_nbits
// Description : Self-checking bench for registro_universal_nbits. Directed
//               sequences plus randomized operations, all compared against an
//               arithmetic reference model of the register contents and shift
//               count. Define ROTATE_EN to also cover the rotate option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registro_universal_nbits;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);
`ifdef ROTATE_EN
    localparam bit c_rot_on = 1'b1;
`else
    localparam bit c_rot_on = 1'b0;
`endif

    logic          clk_tb;
    logic          reset_async;
    logic [1:0]    modo;
    logic [N-1:0]  In;
    logic          ser_in_der;
    logic          ser_in_izq;
    logic          rot;
    logic [N-1:0]  Q;
    logic          ser_out_der;
    logic          ser_out_izq;
    logic [CW-1:0] cuenta;
    logic          vacio;
    logic          vuelta;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    int unsigned m_q;
    int unsigned m_cnt;
    bit          m_vuelta;

    registro_universal_nbits #(.N(N)) dut (
        .clk         (clk_tb),
        .reset_async (reset_async),
        .modo        (modo),
        .In          (In),
        .ser_in_der  (ser_in_der),
        .ser_in_izq  (ser_in_izq),
`ifdef ROTATE_EN
        .rot         (rot),
`endif
        .Q           (Q),
        .ser_out_der (ser_out_der),
        .ser_out_izq (ser_out_izq),
        .cuenta      (cuenta),
        .vacio       (vacio),
        .vuelta      (vuelta)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_q      = 0;
        m_cnt    = 0;
        m_vuelta = 0;
    endtask

    // Behavioural rules: shifts as arithmetic on an integer, count saturating
    // at N, rotations counting modulo N.
    task automatic modelo(input logic [1:0] m, input logic [N-1:0] d,
                          input logic sd, input logic si, input logic r);
        int unsigned mask;
        bit rotating;
        mask     = (1 << N) - 1;
        rotating = r && c_rot_on;
        m_vuelta = 0;
        if (m == 2'b01 || m == 2'b10) begin
            if (m == 2'b01)
                m_q = (m_q >> 1) | ((rotating ? (m_q & 1) : int'(sd)) << (N - 1));
            else
                m_q = ((m_q << 1) | (rotating ? (m_q >> (N - 1)) : int'(si))) & mask;
            if (rotating) begin
                m_cnt    = (m_cnt == N) ? 0 : (m_cnt + 1) % N;
                m_vuelta = (m_cnt == 0);
            end else if (m_cnt < N) begin
                m_cnt = m_cnt + 1;
            end
        end else if (m == 2'b11) begin
            m_q   = d;
            m_cnt = 0;
        end
    endtask

    task automatic comparar_todo(input string tag);
        check_value({tag, "_q"},      32'(Q),           m_q);
        check_value({tag, "_cuenta"}, 32'(cuenta),      m_cnt);
        check_value({tag, "_vacio"},  32'(vacio),       32'(m_cnt == N));
        check_value({tag, "_sder"},   32'(ser_out_der), m_q & 1);
        check_value({tag, "_sizq"},   32'(ser_out_izq), (m_q >> (N - 1)) & 1);
        check_value({tag, "_vuelta"}, 32'(vuelta),      32'(m_vuelta));
    endtask

    // One clocked operation: drive on the falling edge, sample 1 after rising.
    task automatic paso(input string tag, input logic [1:0] m,
                        input logic [N-1:0] d, input logic sd,
                        input logic si, input logic r);
        @(negedge clk_tb);
        modo       = m;
        In         = d;
        ser_in_der = sd;
        ser_in_izq = si;
        rot        = r;
        @(posedge clk_tb);
        #1;
        modelo(m, d, sd, si, r);
        comparar_todo(tag);
    endtask

    initial begin : estimulo
        logic [N-1:0] tab_der [4];
        logic [3:0]   tab_sal;
        tab_der = '{4'b1100, 4'b1110, 4'b1111, 4'b1111};
        tab_sal = 4'b1001;  // ser_out_der before edges 0..3, LSB first

        reset_async = 1'b0;
        modo        = 2'b00;
        In          = '0;
        ser_in_der  = 1'b0;
        ser_in_izq  = 1'b0;
        rot         = 1'b0;
        modelo_reset();
        repeat (2) @(negedge clk_tb);
        comparar_todo("reset");
        reset_async = 1'b1;

        // Asynchronous reset mid-cycle with a non-zero count
        paso("pre_rst_load", 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0);
        paso("pre_rst_der",  2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
        check_value("pre_rst_val", 32'(Q), 32'h0000000b);
        #3;
        modo        = 2'b00;
        reset_async = 1'b0;
        #1;
        modelo_reset();
        comparar_todo("rst_async");
        @(posedge clk_tb);
        #1;
        comparar_todo("rst_held");
        @(negedge clk_tb);
        reset_async = 1'b1;

        // Load then hold
        paso("carga", 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            paso("retener", 2'b00, 4'b0101, 1'b1, 1'b1, 1'b1);
            check_value("retener_const", 32'(Q), 32'hA);
            check_value("retener_cnt", 32'(cuenta), 0);
        end

        // Shift right with saturation
        paso("der_carga", 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_value("der_sout_pre", 32'(ser_out_der), 32'(tab_sal[i]));
            paso("der", 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
            check_value("der_const", 32'(Q), 32'(tab_der[i]));
        end
        check_value("der_vacio", 32'(vacio), 1);
        paso("der_sat", 2'b01, 4'b0000, 1'b1, 1'b0, 1'b0);
        check_value("der_sat_cnt", 32'(cuenta), N);

        // Shift left, then load clears the count
        paso("izq_carga", 2'b11, 4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) paso("izq", 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0);
        check_value("izq_const", 32'(Q), 32'h8);
        check_value("izq_cnt", 32'(cuenta), 3);
        paso("izq_recarga", 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0);
        check_value("izq_recarga_cnt", 32'(cuenta), 0);

        // Unknown select holds
        paso("modo_x", 2'bxx, 4'b1111, 1'b1, 1'b1, 1'b0);

`ifdef ROTATE_EN
        begin : rotacion
            logic [N-1:0] tab_rot [4];
            tab_rot = '{4'b1001, 4'b1100, 4'b0110, 4'b0011};
            paso("rot_carga", 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) begin
                paso("rot", 2'b01, 4'b0000, 1'b0, 1'b0, 1'b1);
                check_value("rot_const", 32'(Q), 32'(tab_rot[i]));
                check_value("rot_vuelta", 32'(vuelta), 32'(i == 3));
            end
            paso("rot_fin", 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
        end
`endif

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            paso("rand", 2'($urandom_range(0, 3)), N'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule : tb_registro_universal_nbits
`default_nettype wire
